mips_program_loader: RTL

- Byte-stream program loader for the MIPS_64 instruction memory.
- Accepts a serial byte stream over a valid/ready handshake and packs each group of 4 bytes (MSB first) into one 32-bit instruction.
- Writes each instruction zero-extended to 64 bits into consecutive instruction-memory words, starting at word 0.
- Holds the processor off while loading; releases it with a start pulse after the HLT instruction has been written.

---
 rtl/mips_program_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mips_program_loader.sv
// ============================================================================
// Module   : mips_program_loader
// Purpose  : Packs a valid/ready byte stream into 32-bit instructions, writes
//            them zero-extended into instruction memory, releases CPU on HLT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_program_loader #(
   parameter int          ADDR_W    = 10,
   parameter int          MEM_DEPTH = 1024,
   parameter logic [5:0]  HLT_OPC   = 6'b111111
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              load_start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              cpu_start,
   output logic              done,
   output logic              err_overflow,
   output logic [ADDR_W:0]   instr_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RECV  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);

   state_t            r_state;
   state_t            w_next;
   logic [1:0]        r_byte_cnt;
   logic [31:0]       r_shreg;
   logic [ADDR_W:0]   r_count;
   logic              r_start_pend;

   logic              w_accept;
   logic              w_restart;
   logic              w_is_hlt;
   logic [ADDR_W:0]   w_count_inc;

   assign w_accept    = rx_valid && (r_state == S_RECV);
   assign w_restart   = load_start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
   assign w_is_hlt    = (r_shreg[31:26] == HLT_OPC);
   assign w_count_inc = r_count + c_ONE;

   assign mem_addr    = r_count[ADDR_W-1:0];
   assign mem_wdata   = {32'h0, r_shreg};
   assign instr_count = r_count;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      rx_ready     = 1'b0;
      mem_we       = 1'b0;
      cpu_hold     = 1'b1;
      cpu_start    = 1'b0;
      done         = 1'b0;
      err_overflow = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_restart) w_next = S_RECV;
         end
         S_RECV: begin
            rx_ready = 1'b1;
            if (w_accept && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
         end
         S_WRITE: begin
            mem_we = 1'b1;
            // HLT wins even when it lands in the last slot
            if (w_is_hlt)                     w_next = S_DONE;
            else if (w_count_inc == c_DEPTH)  w_next = S_ERR;
            else                              w_next = S_RECV;
         end
         S_DONE: begin
            cpu_hold  = 1'b0;
            cpu_start = r_start_pend;
            done      = !r_start_pend;
            if (w_restart) w_next = S_RECV;
         end
         S_ERR: begin
            err_overflow = 1'b1;
            if (w_restart) w_next = S_RECV;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         r_byte_cnt   <= 2'd0;
         r_shreg      <= 32'h0;
         r_count      <= '0;
         r_start_pend <= 1'b0;
      end else begin
         // Marks the first cycle in DONE, which carries the start pulse
         r_start_pend <= (r_state == S_WRITE) && w_is_hlt;
         if (w_restart) begin
            r_byte_cnt <= 2'd0;
            r_shreg    <= 32'h0;
            r_count    <= '0;
         end else begin
            if (w_accept) begin
               r_shreg    <= {r_shreg[23:0], rx_data};
               r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (r_state == S_WRITE) begin
               r_count <= w_count_inc;
            end
         end
      end
   end

endmodule

`default_nettype wire
